// File: rtl/proc_loader_pkg.sv
// proc_loader_pkg: shared ctrl encodings, frame width and loader state codes
package proc_loader_pkg;
    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_IWR  = 2'b01;
    localparam logic [1:0] CTRL_DWR  = 2'b10;
    localparam logic [1:0] CTRL_RUN  = 2'b11;
    localparam int FRAME_W = 12;
    typedef logic [FRAME_W-1:0] frame_t;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_ARM   = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
endpackage

// File: rtl/proc_loader_if.sv
// proc_loader_if: load/run command port
//  valid, ready : handshake, command taken when both are 1
//  run          : 1 = run command, tgt/addr/data ignored
//  tgt          : 0 = icache, 1 = dcache
//  addr, data   : cache address and byte
interface proc_loader_if;
    logic       valid;
    logic       ready;
    logic       run;
    logic       tgt;
    logic [3:0] addr;
    logic [7:0] data;
    modport master (output valid, run, tgt, addr, data, input ready);
    modport slave  (input valid, run, tgt, addr, data, output ready);
endinterface

// File: rtl/proc_loader_sclk_sync.sv
// proc_loader_sclk_sync: 2FF synchroniser plus edge register, rise/fall strobes
//  clk, rst_n : system clock, async active-low reset
//  din        : asynchronous input
//  rise, fall : 1-cycle strobes, acted on 3 clk edges after din changes
module proc_loader_sclk_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else        sr <= {sr[1:0], din};
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/proc_loader.sv
// proc_loader: serialises load commands onto ctrl/miso and launches runs of the tiny processor
//  clk, rst_n : system clock, async active-low reset
//  cmd        : command port (slave)
//  sclk_in    : processor shift clock, asynchronous
//  done_in    : processor done flag
//  ctrl_out   : 00 idle, 01 icache load, 10 dcache load, 11 run
//  miso_out   : frame data, MSB first
//  busy       : not idle
//  run_done   : pulse, run finished normally
//  run_tout   : pulse, run aborted by timeout
module proc_loader
    import proc_loader_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 2,
    parameter int RUN_TO    = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    proc_loader_if.slave     cmd,
    input  logic             sclk_in,
    input  logic             done_in,
    output logic [1:0]       ctrl_out,
    output logic             miso_out,
    output logic             busy,
    output logic             run_done,
    output logic             run_tout
);
    localparam int TW = $clog2(RUN_TO + SETUP_CYC + GAP_CYC + 2);
    logic [2:0]    state;
    logic          live;
    logic [3:0]    cnt;
    logic [TW-1:0] tmr;
    frame_t        frame;
    logic          rise, fall;
    proc_loader_sclk_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sclk_in),
        .rise (rise),
        .fall (fall)
    );
    // live keeps cmd_ready low through reset and its first release cycle
    assign cmd.ready = live && state == S_IDLE;
    assign busy      = state != S_IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            live     <= 1'b0;
            cnt      <= '0;
            tmr      <= '0;
            frame    <= '0;
            ctrl_out <= CTRL_IDLE;
            miso_out <= 1'b0;
            run_done <= 1'b0;
            run_tout <= 1'b0;
        end else begin
            live     <= 1'b1;
            run_done <= 1'b0;
            run_tout <= 1'b0;
            case (state)
                S_IDLE: if (cmd.valid && cmd.ready) begin
                    tmr      <= '0;
                    frame    <= {cmd.addr, cmd.data};
                    ctrl_out <= cmd.run ? CTRL_RUN : cmd.tgt ? CTRL_DWR : CTRL_IWR;
                    state    <= cmd.run ? S_ARM : S_SETUP;
                end
                S_SETUP: begin
                    tmr <= tmr + 1'b1;
                    if (tmr == TW'(SETUP_CYC - 1)) begin
                        miso_out <= frame[FRAME_W-1];
                        cnt      <= '0;
                        state    <= S_SHIFT;
                    end
                end
                // cnt counts bits already sampled; a fall drives the bit the next rise samples
                S_SHIFT: if (rise) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == 4'(FRAME_W - 1)) begin
                        ctrl_out <= CTRL_IDLE;
                        miso_out <= 1'b0;
                        tmr      <= '0;
                        state    <= S_GAP;
                    end
                end else if (fall) begin
                    miso_out <= frame[4'(FRAME_W - 1) - cnt];
                end
                S_GAP: begin
                    tmr <= tmr + 1'b1;
                    if (tmr == TW'(GAP_CYC - 1)) state <= S_IDLE;
                end
                // ctrl drops on the edge that sees done so the processor does not re-enter EXEC
                S_ARM, S_WAIT: if (state == S_WAIT && done_in) begin
                    ctrl_out <= CTRL_IDLE;
                    run_done <= 1'b1;
                    tmr      <= '0;
                    state    <= S_GAP;
                end else if (RUN_TO != 0 && tmr == TW'(RUN_TO - 1)) begin
                    ctrl_out <= CTRL_IDLE;
                    run_tout <= 1'b1;
                    tmr      <= '0;
                    state    <= S_GAP;
                end else begin
                    tmr <= tmr + 1'b1;
                    if (!done_in) state <= S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_proc_loader.sv
// tb_proc_loader: randomized loads and runs against a processor-side model of the load path
module tb_proc_loader;
    import proc_loader_pkg::*;
    localparam int GAP = 2, RTO = 64, LIM = 3000;
    logic clk = 0, rst_n = 0, sclk = 0, done = 1;
    logic [1:0] ctrl;
    logic miso, busy, run_done, run_tout;
    int tests = 0, fails = 0;
    logic [7:0] mem_i [16], mem_d [16], exp_i [16], exp_d [16];
    proc_loader_if cmd_if ();
    proc_loader #(.SETUP_CYC(2), .GAP_CYC(GAP), .RUN_TO(RTO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .sclk_in(sclk), .done_in(done),
        .ctrl_out(ctrl), .miso_out(miso), .busy(busy), .run_done(run_done), .run_tout(run_tout)
    );
    always #5 clk = ~clk;
    task automatic send_cmd(input logic run, input logic tgt, input logic [3:0] a,
                            input logic [7:0] d);
        int w = 0;
        cmd_if.run = run; cmd_if.tgt = tgt; cmd_if.addr = a; cmd_if.data = d; cmd_if.valid = 1;
        while (!cmd_if.ready && w < LIM) begin @(negedge clk); w++; end
        tests++;
        if (!cmd_if.ready) begin fails++; $display("FAIL accept: ready=%b required 1", cmd_if.ready); end
        @(negedge clk);
        cmd_if.valid = 0;
    endtask
    // processor side of one frame: sample miso on each sclk rise, commit on cs release
    task automatic serve(input int stall, output logic [1:0] code, output logic [11:0] bits,
                         output int gapn, output bit ok, output bit stall_ok);
        int n = 0;
        logic m;
        code = 0; bits = 0; gapn = 0; ok = 1; stall_ok = 1;
        while (ctrl == CTRL_IDLE && n < LIM) begin @(negedge clk); n++; end
        if (ctrl == CTRL_IDLE) begin ok = 0; return; end
        code = ctrl;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            sclk = 1;
            bits = {bits[10:0], miso};
            if (ctrl !== code) ok = 0;
            if (i + 1 == stall) begin
                m = miso;
                repeat (100) begin
                    @(negedge clk);
                    if (miso !== m || ctrl !== code || !busy) stall_ok = 0;
                end
            end
            if (i < 11) begin
                repeat (4) @(negedge clk);
                sclk = 0;
                repeat (4) @(negedge clk);
            end
        end
        n = 0;
        do begin
            @(negedge clk); n++;
            if (n == 4) sclk = 0;
            if (ctrl == CTRL_IDLE) begin
                if (busy) gapn++;
                if (miso !== 1'b0) ok = 0;
            end else if (ctrl !== code) ok = 0;
        end while (busy && n < LIM);
        sclk = 0;
        if (busy) ok = 0;
        if (code == CTRL_IWR) mem_i[bits[11:8]] = bits[7:0];
        if (code == CTRL_DWR) mem_d[bits[11:8]] = bits[7:0];
    endtask
    task automatic test_load(input logic tgt, input logic [3:0] a, input logic [7:0] d, input int stall);
        logic [1:0] code; logic [11:0] bits; int gapn; bit ok, sok;
        fork
            send_cmd(0, tgt, a, d);
            serve(stall, code, bits, gapn, ok, sok);
        join
        if (tgt) exp_d[a] = d; else exp_i[a] = d;
        tests++; if (code !== (tgt ? CTRL_DWR : CTRL_IWR)) begin fails++; $display("FAIL load_ctrl: got %b need %b", code, tgt ? CTRL_DWR : CTRL_IWR); end
        tests++; if (bits !== {a, d}) begin fails++; $display("FAIL load_bits: got %h need %h", bits, {a, d}); end
        tests++; if (gapn != GAP) begin fails++; $display("FAIL load_gap: got %0d need %0d", gapn, GAP); end
        tests++; if (!ok) begin fails++; $display("FAIL load_frame_ctrl: ctrl/miso off during frame or gap, got 0 need 1"); end
        if (stall != 0) begin
            tests++; if (!sok) begin fails++; $display("FAIL stall: got 0 need 1 (SHIFT held, miso stable)"); end
        end
        tests++; if (busy !== 1'b0 || cmd_if.ready !== 1'b1) begin fails++; $display("FAIL load_idle: busy=%b ready=%b need 0 1", busy, cmd_if.ready); end
    endtask
    task automatic test_reset;
        @(negedge clk);
        tests++; if ({ctrl, miso, cmd_if.ready, busy, run_done, run_tout} !== 7'b0) begin
            fails++; $display("FAIL reset_state: got %b need 0000000", {ctrl, miso, cmd_if.ready, busy, run_done, run_tout}); end
        rst_n = 1;
        @(negedge clk);
        tests++; if (cmd_if.ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_release: ready=%b busy=%b need 1 0", cmd_if.ready, busy); end
    endtask
    task automatic test_reset_midframe;
        fork
            send_cmd(0, 1'b0, 4'h7, 8'h3C);
            begin
                int n = 0;
                while (ctrl == CTRL_IDLE && n < LIM) begin @(negedge clk); n++; end
                repeat (4) @(negedge clk);
                repeat (3) begin sclk = 1; repeat (4) @(negedge clk); sclk = 0; repeat (4) @(negedge clk); end
            end
        join
        tests++; if (busy !== 1'b1 || ctrl !== CTRL_IWR) begin fails++; $display("FAIL midframe: busy=%b ctrl=%b need 1 01", busy, ctrl); end
        #2 rst_n = 0;
        #1;
        tests++; if (ctrl !== CTRL_IDLE || miso !== 1'b0) begin fails++; $display("FAIL async_reset: ctrl=%b miso=%b need 00 0", ctrl, miso); end
        @(negedge clk) rst_n = 1;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || cmd_if.ready !== 1'b1) begin fails++; $display("FAIL reset_recover: busy=%b ready=%b need 0 1", busy, cmd_if.ready); end
    endtask
    task automatic test_run;
        bit ok = 1; int pulses = 0;
        fork
            send_cmd(1, 1'b0, 4'h0, 8'h00);
            begin
                int n = 0;
                while (ctrl != CTRL_RUN && n < LIM) begin @(negedge clk); n++; end
                repeat (3) begin if (ctrl !== CTRL_RUN) ok = 0; @(negedge clk); end
                done = 0;
                repeat (50) begin @(negedge clk); if (ctrl !== CTRL_RUN) ok = 0; end
                done = 1;
                @(negedge clk);
            end
        join
        tests++; if (!ok) begin fails++; $display("FAIL run_ctrl: ctrl left 11 during run, got 0 need 1"); end
        tests++; if (ctrl !== CTRL_IDLE || run_done !== 1'b1 || run_tout !== 1'b0) begin
            fails++; $display("FAIL run_end: ctrl=%b done=%b tout=%b need 00 1 0", ctrl, run_done, run_tout); end
        for (int i = 0; i < 10; i++) begin @(negedge clk); pulses += run_done; end
        tests++; if (pulses != 0 || busy !== 1'b0) begin fails++; $display("FAIL run_pulse: extra=%0d busy=%b need 0 0", pulses, busy); end
    endtask
    task automatic test_timeout;
        int n = 0;
        fork
            send_cmd(1, 1'b0, 4'h0, 8'h00);
            begin
                int w = 0;
                while (ctrl != CTRL_RUN && w < LIM) begin @(negedge clk); w++; end
                done = 0;
                while (ctrl == CTRL_RUN && n < LIM) begin n++; @(negedge clk); end
            end
        join
        tests++; if (n != RTO) begin fails++; $display("FAIL tout_len: got %0d need %0d", n, RTO); end
        tests++; if (ctrl !== CTRL_IDLE || run_tout !== 1'b1 || run_done !== 1'b0) begin
            fails++; $display("FAIL tout_end: ctrl=%b tout=%b done=%b need 00 1 0", ctrl, run_tout, run_done); end
        repeat (GAP + 1) @(negedge clk);
        tests++; if (busy !== 1'b0 || cmd_if.ready !== 1'b1) begin fails++; $display("FAIL tout_idle: busy=%b ready=%b need 0 1", busy, cmd_if.ready); end
        done = 1;
    endtask
    task automatic test_back_to_back;
        logic [3:0] a1 = 4'($urandom), a2 = 4'($urandom);
        logic [7:0] d1 = 8'($urandom), d2 = 8'($urandom);
        logic [1:0] c1, c2; logic [11:0] b1, b2; int g1, g2, w = 0; bit o1, o2, s, early = 0;
        fork
            begin
                cmd_if.run = 0; cmd_if.tgt = 0; cmd_if.addr = a1; cmd_if.data = d1; cmd_if.valid = 1;
                @(negedge clk);
                cmd_if.tgt = 1; cmd_if.addr = a2; cmd_if.data = d2;
                while (!cmd_if.ready && w < LIM) begin
                    if (busy && cmd_if.ready) early = 1;
                    @(negedge clk); w++;
                end
                @(negedge clk);
                cmd_if.valid = 0;
            end
            begin
                serve(0, c1, b1, g1, o1, s);
                serve(0, c2, b2, g2, o2, s);
            end
        join
        exp_i[a1] = d1; exp_d[a2] = d2;
        tests++; if (early || w < 90) begin fails++; $display("FAIL b2b_holdoff: waited %0d need >=90", w); end
        tests++; if ({c1, b1} !== {CTRL_IWR, a1, d1}) begin fails++; $display("FAIL b2b_first: got %b %h need 01 %h", c1, b1, {a1, d1}); end
        tests++; if ({c2, b2} !== {CTRL_DWR, a2, d2} || !o1 || !o2) begin fails++; $display("FAIL b2b_second: got %b %h need 10 %h", c2, b2, {a2, d2}); end
    endtask
    initial begin
        int mm = 0;
        cmd_if.valid = 0; cmd_if.run = 0; cmd_if.tgt = 0; cmd_if.addr = 0; cmd_if.data = 0;
        for (int i = 0; i < 16; i++) begin mem_i[i] = 0; mem_d[i] = 0; exp_i[i] = 0; exp_d[i] = 0; end
        test_reset();
        test_load(1'b0, 4'h3, 8'hA5, 0);
        test_load(1'b1, 4'hF, 8'h00, 0);
        test_load(1'b0, 4'($urandom), 8'($urandom), 5);
        test_run();
        test_timeout();
        test_back_to_back();
        repeat (6) test_load(1'($urandom), 4'($urandom), 8'($urandom), 0);
        test_reset_midframe();
        test_load(1'b1, 4'($urandom), 8'($urandom), 0);
        for (int i = 0; i < 16; i++) mm += int'(mem_i[i] !== exp_i[i]) + int'(mem_d[i] !== exp_d[i]);
        tests++; if (mm != 0) begin fails++; $display("FAIL cache_image: %0d entries differ, need 0", mm); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, need finish");
        $fatal(1, "watchdog");
    end
endmodule
